// File: rtl/pixel_ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_ram_pkg
// Description : Shared image geometry, widths, return-tag type and the
//               coordinate-to-address translation for the 6x6 pixel RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_ram_pkg;

    localparam int NREQ    = 3;   // pixel-walking requesters sharing the RAM
    localparam int XSZ     = 3;   // x coordinate width
    localparam int YSZ     = 3;   // y coordinate width
    localparam int ADDR_SZ = 6;   // RAM address width
    localparam int COL_SZ  = 3;   // pixel colour width
    localparam int IMG_W   = 6;   // image width in pixels
    localparam int IMG_H   = 6;   // image height in pixels

    // Travels down the read-latency pipeline alongside each issued access
    typedef struct packed {
        logic            valid;
        logic [NREQ-1:0] id;     // one-hot originating requester
        logic            oob;    // coordinate was outside the image
    } ret_tag_t;

    // Row-major address, computed at full address width so no partial product truncates
    function automatic logic [ADDR_SZ-1:0] xy_to_addr(input logic [XSZ-1:0] x,
                                                      input logic [YSZ-1:0] y);
        return ADDR_SZ'(y) * ADDR_SZ'(IMG_W) + ADDR_SZ'(x);
    endfunction

    // True when the coordinate lies inside the image
    function automatic logic in_image(input logic [XSZ-1:0] x,
                                      input logic [YSZ-1:0] y);
        return (x < XSZ'(IMG_W)) && (y < YSZ'(IMG_H));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_ram_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter with a combinational one-hot grant and a
//               registered last-grant pointer. Search begins one past the
//               last winner and wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt
);

    localparam int               PTR_W       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTR_W-1:0] c_LAST_INIT = PTR_W'(NREQ - 1);

    logic [PTR_W-1:0] r_last;
    logic [PTR_W-1:0] w_cand;
    logic [PTR_W-1:0] w_winner;
    logic [NREQ-1:0]  w_gnt;
    logic             w_found;

    // Find the first active request after the last winner, wrapping around
    always_comb begin
        w_gnt    = '0;
        w_winner = r_last;
        w_found  = 1'b0;
        w_cand   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = PTR_W'((int'(r_last) + k) % NREQ);
            if (!w_found && req[w_cand]) begin
                w_found        = 1'b1;
                w_winner       = w_cand;
                w_gnt[w_cand]  = 1'b1;
            end
        end
    end

    // No grant may escape while the block is held in reset
    assign gnt = resetn ? w_gnt : '0;

    // Remember the winner; hold the pointer on idle cycles
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last <= c_LAST_INIT;
        end else if (w_found) begin
            r_last <= w_winner;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pixel_ram_arbiter
// Description : Shares the read-only 6x6 pixel RAM between the edge/finder
//               walkers. Arbitrates round-robin, translates (x,y) to a RAM
//               address and routes the read data back after RD_LAT cycles.
//               Off-image coordinates return background without a RAM read.
//               Image geometry and widths come from pixel_ram_pkg.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_ram_arbiter
    import pixel_ram_pkg::*;
#(
    parameter int RD_LAT = 1          // RAM read latency, 1..4 cycles
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*XSZ-1:0]   req_x,
    input  logic [NREQ*YSZ-1:0]   req_y,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rvalid,
    output logic [COL_SZ-1:0]     rdata,
    output logic                  oob,
    output logic [ADDR_SZ-1:0]    ram_address,
    input  logic [COL_SZ-1:0]     ram_q
);

    logic [NREQ-1:0] w_gnt;
    logic [XSZ-1:0]  w_selX;
    logic [YSZ-1:0]  w_selY;
    logic            w_any;
    logic            w_inImage;
    ret_tag_t        w_newTag;
    ret_tag_t        w_headTag;
    ret_tag_t        r_tagPipe [RD_LAT];

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rrArbiter (
        .clk    (clk),
        .resetn (resetn),
        .req    (req),
        .gnt    (w_gnt)
    );

    assign gnt = w_gnt;

    // Pick the coordinate of the granted lane; other lanes are ignored
    always_comb begin
        w_selX = '0;
        w_selY = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_selX = req_x[i*XSZ +: XSZ];
                w_selY = req_y[i*YSZ +: YSZ];
            end
        end
    end

    assign w_any     = |w_gnt;
    assign w_inImage = in_image(w_selX, w_selY);

    // Address parks at 0 when idle or when the walker has stepped off the image
    assign ram_address = (w_any && w_inImage) ? xy_to_addr(w_selX, w_selY) : '0;

    assign w_newTag = '{valid: w_any, id: w_gnt, oob: w_any && !w_inImage};

    // Tag shift register matching the RAM latency; reset drops accesses in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_tagPipe[i] <= '0;
            end
        end else begin
            r_tagPipe[0] <= w_newTag;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tagPipe[i] <= r_tagPipe[i-1];
            end
        end
    end

    assign w_headTag = r_tagPipe[RD_LAT-1];

    // Return side: valid and oob straight from the tag, data gated to 0 unless a real in-image hit
    assign rvalid = w_headTag.valid ? w_headTag.id : '0;
    assign oob    = w_headTag.valid && w_headTag.oob;
    assign rdata  = (w_headTag.valid && !w_headTag.oob) ? ram_q : '0;

endmodule
`default_nettype wire

// File: doc/pixel_ram_arbiter.md
Name: pixel_ram_arbiter

Overview:
- Shares one read-only 36x3 image RAM (6x6 pixels, 3-bit colour) between several pixel-walking requesters: top/bottom finder, right-edge finder, left-edge finder.
- Each requester presents an (x,y) coordinate. The block arbitrates round-robin, translates the coordinate to a RAM address and issues it.
- Read data is returned to the originating requester with a fixed latency.
- Out-of-image coordinates return background (0) without touching the RAM, so edge walkers that step off the image see an edge.

Parameters:
- NREQ, 3, number of requesters
- XSZ, 3, x coordinate width
- YSZ, 3, y coordinate width
- ADDR_SZ, 6, RAM address width
- COL_SZ, 3, pixel colour width
- IMG_W, 6, image width in pixels (address = y*IMG_W + x)
- IMG_H, 6, image height in pixels
- RD_LAT, 1, RAM read latency in cycles (1..4)

Ports:
- clk  in  1  system clock, all logic on posedge
- resetn  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester read request; held high until granted
- req_x  in  NREQ*XSZ  packed x coordinates; requester i uses bits [i*XSZ +: XSZ]
- req_y  in  NREQ*YSZ  packed y coordinates; same packing
- gnt  out  NREQ  one-hot grant, combinational, same cycle as accepted request
- rvalid  out  NREQ  one-hot read-data valid for the originating requester
- rdata  out  COL_SZ  pixel value, broadcast, qualified by rvalid
- oob  out  1  asserted with rvalid when the returned pixel was out of image (rdata=0)
- ram_address  out  ADDR_SZ  address to RAM, combinational from granted coordinate
- ram_q  in  COL_SZ  RAM read data, valid RD_LAT cycles after address

Behaviour:
- Reset (async, resetn=0):
  - rvalid=0, rdata=0, oob=0.
  - Tag pipeline cleared; requests in flight are discarded and never return rvalid.
  - Round-robin last-grant pointer = NREQ-1, so requester 0 has top priority.
  - gnt=0 while resetn=0.
- Arbitration:
  - At most one grant per cycle.
  - Search order starts at (last+1) mod NREQ and wraps. The first requester with req=1 wins.
  - The pointer updates to the winner on the clock edge. With no requests, the pointer holds and gnt=0.
- Handshake:
  - Request accepted in cycle T when gnt[i]=1 in T.
  - The requester may change x/y or drop req from T+1.
  - A requester may issue back-to-back requests. It receives consecutive grants only if no other requester is waiting.
- Issue:
  - In cycle T, ram_address = y*IMG_W + x of the winner. Use zero-extended unsigned arithmetic; no truncation within ADDR_SZ for in-range coordinates.
  - With no grant, ram_address holds 0.
- Out-of-bounds: x>=IMG_W or y>=IMG_H.
  - The request is still granted normally and ram_address=0.
  - The tag is marked oob. On return, rdata=0 (ram_q ignored) and oob=1.
- Return:
  - A tag shift register of depth RD_LAT carries {valid, one-hot id, oob}.
  - In cycle T+RD_LAT, rvalid[id]=1 for one cycle and rdata=ram_q (or 0 if oob).
  - rdata and oob are registered alongside, so rvalid, rdata and oob align exactly.
  - When rvalid=0, rdata=0 and oob=0.
- Throughput: one access per cycle sustained, with no bubbles between different requesters.
- Simultaneous events:
  - A grant and a return in the same cycle are independent.
  - A return to requester i can coincide with a new grant to i.
- Req dropped before grant: no effect, no pointer change.
- Coordinates on non-requesting lanes are ignored.

Decomposition:
- Package pixel_ram_pkg holds:
  - the image constants IMG_W=6, IMG_H=6, and widths XSZ, YSZ, ADDR_SZ, COL_SZ;
  - the address function xy_to_addr(x,y), shared with the existing address translation;
  - the return-tag struct {valid, id, oob}.
- Sub-module rr_arbiter (parameter NREQ): req vector in, one-hot gnt out, internal last-grant pointer with the async active-low resetn. Kept separate so it can be reused for other shared resources.

Test Plan:
- Single read: req[1]=1, x=2, y=3, RD_LAT=1. Expect gnt[1] same cycle, ram_address=20; next cycle rvalid[1]=1, rdata=ram_q(20), oob=0.
- Contention: all three req=1 continuously from reset. Expect grants cycle 0,1,2,0,1,2; rvalid follows the same order delayed by RD_LAT, with no gaps.
- Out-of-bounds: req[2]=1, x=6, y=0 (walker off right edge). Expect gnt[2], ram_address=0; rvalid[2]=1, rdata=0, oob=1, even when ram_q=7.
- Corner address: x=5, y=5. Expect ram_address=35; x=0, y=0 gives 0.
- Reset mid-flight: RD_LAT=3, grant to requester 0, assert resetn=0 one cycle later. Expect no rvalid ever for that request; after release, requester 0 wins first.
- Idle and drop: req pulses for one cycle while another requester holds the grant. Expect no grant and no pointer change; the next round starts from the previous pointer.
